// File: rtl/bus_cycle_timer.sv
// Purpose : 68k DTACK/BERR generator behind the address decoder. It inserts wait states for
//           on-board ROM/RAM, and it times out IO, expansion and CPU-space cycles into BERR.
// Latency : DTACK asserts N+1 clocks after as_s falls (N = ROM_WAIT/RAM_WAIT), which is N+3 clocks
//           after AS_n falls. BERR asserts BERR_TIMEOUT+2 clocks after AS_n falls. Both release
//           2 clocks after AS_n rises.
// Backpressure: none; the CPU holds AS_n until it is acknowledged, and this block only follows AS_n.
//
// Ports:
//   i_CLK, i_RESET_n            clock, asynchronous active-low reset
//   i_AS_n, i_EXTDTACK_n        asynchronous bus strobes (synchronised internally)
//   i_CPUSP_n, i_ROMSEL_n,
//   i_RAMSEL_n                  decoder outputs, stable while AS_n is low
//   o_DTACK_n, o_BERR_n         open-drain: driven 0 or released (Z)
//   o_BERR_EVENT                one-clock pulse on entry to bus error
module bus_cycle_timer #(
  parameter int unsigned ROM_WAIT     = 2,
  parameter int unsigned RAM_WAIT     = 0,
  parameter int unsigned BERR_TIMEOUT = 64
) (
  input  logic i_CLK,
  input  logic i_RESET_n,
  input  logic i_AS_n,
  input  logic i_CPUSP_n,
  input  logic i_ROMSEL_n,
  input  logic i_RAMSEL_n,
  input  logic i_EXTDTACK_n,
  output wire  o_DTACK_n,
  output wire  o_BERR_n,
  output logic o_BERR_EVENT
);

  localparam logic [15:0] ROM_CNT  = 16'(ROM_WAIT);
  localparam logic [15:0] RAM_CNT  = 16'(RAM_WAIT);
  localparam logic [15:0] TIMEOUT_MAX = 16'(BERR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_EXT,
    ST_DONE,
    ST_BERR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        as_s1_q, as_s1_d;
  logic        as_s_q, as_s_d;
  logic        ext_s1_q, ext_s1_d;
  logic        ext_s_q, ext_s_d;
  logic        dtack_oe_q, dtack_oe_d;
  logic        berr_oe_q, berr_oe_d;
  logic        berr_evt_q, berr_evt_d;

  // The state register captures the first synchroniser stage on the same edge as as_s does.
  // This makes the FSM advance on the edge where as_s itself changes: the FSM flop acts as a
  // second stage in parallel with as_s.
  // as_hi is the value that as_s takes on this edge. as_fall is true only when as_s was high
  // for at least one clock, so each AS assertion is accepted exactly once.
  logic as_hi;
  logic as_fall;
  logic ext_lo;

  assign as_hi   = as_s1_q;
  assign as_fall = as_s_q & ~as_s1_q;
  assign ext_lo  = ~ext_s_q;

  always_comb begin
    as_s1_d    = i_AS_n;
    as_s_d     = as_s1_q;
    ext_s1_d   = i_EXTDTACK_n;
    ext_s_d    = ext_s1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (as_fall) begin
          // ROM wins when both selects are low.
          if (!i_CPUSP_n && !i_ROMSEL_n) begin
            state_d = ST_WAIT;
            cnt_d   = ROM_CNT;
          end else if (!i_CPUSP_n && !i_RAMSEL_n) begin
            state_d = ST_WAIT;
            cnt_d   = RAM_CNT;
          end else begin
            state_d = ST_EXT;
          end
        end
      end

      ST_WAIT: begin
        if (as_hi) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          state_d = ST_ACK;
        end
      end

      ST_ACK: begin
        if (as_hi) state_d = ST_IDLE;
      end

      ST_EXT: begin
        // The counter saturates instead of wrapping. An external ack beats a timeout
        // that occurs on the same clock.
        cnt_d = (cnt_q == TIMEOUT_MAX) ? cnt_q : cnt_q + 16'd1;
        if (as_hi) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (ext_lo) begin
          state_d = ST_DONE;
        end else if (cnt_q == TIMEOUT_MAX) begin
          state_d = ST_BERR;
        end
      end

      ST_DONE, ST_BERR: begin
        // A late external DTACK is deliberately ignored here.
        if (as_hi) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    dtack_oe_d = (state_d == ST_ACK);
    berr_oe_d  = (state_d == ST_BERR);
    berr_evt_d = (state_d == ST_BERR) && (state_q != ST_BERR);
  end

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      as_s1_q    <= 1'b1;
      as_s_q     <= 1'b1;
      ext_s1_q   <= 1'b1;
      ext_s_q    <= 1'b1;
      dtack_oe_q <= 1'b0;
      berr_oe_q  <= 1'b0;
      berr_evt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      as_s1_q    <= as_s1_d;
      as_s_q     <= as_s_d;
      ext_s1_q   <= ext_s1_d;
      ext_s_q    <= ext_s_d;
      dtack_oe_q <= dtack_oe_d;
      berr_oe_q  <= berr_oe_d;
      berr_evt_q <= berr_evt_d;
    end
  end

  // Only registered enables reach the pins. Reset clears them asynchronously, so a reset
  // in the middle of a cycle releases the bus at once.
  assign o_DTACK_n    = dtack_oe_q ? 1'b0 : 1'bz;
  assign o_BERR_n     = berr_oe_q  ? 1'b0 : 1'bz;
  assign o_BERR_EVENT = berr_evt_q;

endmodule

// File: doc/bus_cycle_timer.md
Name: bus_cycle_timer

Overview:
- Sequential DTACK/BERR generator that sits directly downstream of the address decoder.
- Consumes the decoder's chip selects and the CPU's AS_n, and inserts parameterised wait states before asserting DTACK for on-board ROM/RAM.
- Watches cycles it does not acknowledge itself (IO, expansion, CPU space) and asserts BERR if no external DTACK arrives within a timeout.
- Outputs are open-drain style (0 or Z) onto the shared 68k bus.

Parameters:
ROM_WAIT, 2, wait-state clocks before DTACK for ROM cycles (0..255)
RAM_WAIT, 0, wait-state clocks before DTACK for RAM cycles (0..255)
BERR_TIMEOUT, 64, clocks without DTACK before BERR asserts (2..65535)

Ports:
i_CLK  input  1  system clock
i_RESET_n  input  1  asynchronous active-low reset
i_AS_n  input  1  CPU address strobe, asynchronous to i_CLK
i_CPUSP_n  input  1  low during normal (non-CPU-space) cycles
i_ROMSEL_n  input  1  low when decoder selects ROM (EVENROM_n AND ODDROM_n)
i_RAMSEL_n  input  1  low when decoder selects RAM (EVENRAM_n AND ODDRAM_n)
i_EXTDTACK_n  input  1  DTACK from IO/expansion, asynchronous
o_DTACK_n  output  1  0 when acknowledging, else Z
o_BERR_n  output  1  0 when bus error, else Z
o_BERR_EVENT  output  1  one-clock pulse when BERR first asserts

Behaviour:
- Reset (async, i_RESET_n low): state IDLE, counters 0, synchronisers 1, o_DTACK_n=Z, o_BERR_n=Z, o_BERR_EVENT=0. Mid-cycle reset releases both outputs immediately.
- i_AS_n and i_EXTDTACK_n each pass through a 2-flop synchroniser (as_s, ext_s). All decisions use the synchronised values.
- Selects are sampled on the same clock as the as_s falling edge. They are stable by then because the decoder is combinational on the address, which is valid before AS.
- Counter width is 16 bits. Wait counts load as zero-extended values.
- IDLE: stay while as_s=1. On as_s=0:
  - ROM cycle (i_CPUSP_n=0, i_ROMSEL_n=0): load cnt=ROM_WAIT and go to WAIT. ROM takes priority if both selects are low.
  - RAM cycle (i_CPUSP_n=0, i_RAMSEL_n=0): load cnt=RAM_WAIT and go to WAIT.
  - Anything else, including CPU-space cycles: cnt=0 and go to EXT.
- WAIT: while cnt!=0, decrement. When cnt==0, go to ACK on the next clock.
  - A zero-wait cycle therefore goes IDLE→WAIT→ACK.
  - Result: DTACK asserts N+1 clocks after as_s falls, where N is the wait parameter.
- ACK: o_DTACK_n=0. Hold until as_s=1, then go to IDLE. DTACK releases on the same edge the state leaves ACK.
- EXT: cnt increments every clock.
  - ext_s=0: go to DONE. This block never drives DTACK for external cycles.
  - cnt reaches BERR_TIMEOUT-1 with ext_s still 1: go to BERR.
  - If both happen on the same clock, ext_s wins and the cycle goes to DONE.
- DONE: passive. Hold until as_s=1, then go to IDLE.
- BERR: o_BERR_n=0. o_BERR_EVENT=1 only on the first clock in BERR. Hold until as_s=1, then go to IDLE.
  - A late external DTACK arriving while in BERR is ignored.
- Early AS negation: if as_s=1 in WAIT or EXT, go to IDLE with no DTACK or BERR. The cycle is aborted and counters are cleared.
- Back-to-back cycles: IDLE requires as_s=1 for at least one clock before accepting a new cycle, so each AS assertion produces exactly one ack or error.
- Counter must not wrap. In EXT it saturates at BERR_TIMEOUT-1.
- Outputs are registered. Z is expressed as an output-enable driven from state flops, so there is no combinational path from inputs to outputs.

Test Plan:
- Reset mid-ACK: assert i_RESET_n=0 while o_DTACK_n=0 → o_DTACK_n=Z and o_BERR_n=Z immediately, state IDLE; after release, no DTACK until a new AS falling edge.
- ROM read, ROM_WAIT=2: i_ROMSEL_n=0, i_AS_n falls → o_DTACK_n=0 exactly 5 clocks after i_AS_n falls (2 sync + 1 + 2 wait) → released 2 clocks after i_AS_n rises.
- RAM zero-wait: RAM_WAIT=0, i_RAMSEL_n=0 → o_DTACK_n=0 3 clocks after i_AS_n falls; i_ROMSEL_n=0 and i_RAMSEL_n=0 together → ROM timing (5 clocks).
- IO cycle with external ack: both selects high, i_EXTDTACK_n falls 10 clocks after AS → o_DTACK_n stays Z, o_BERR_n stays Z for 100 clocks of held AS, o_BERR_EVENT never pulses.
- Timeout, BERR_TIMEOUT=64: unmapped cycle with no external DTACK → o_BERR_n=0 and a single o_BERR_EVENT pulse at clock 2+1+63 after AS falls; held until AS rises + 2 clocks; i_EXTDTACK_n asserted afterwards has no effect.
- Aborted cycle: ROM_WAIT=200, AS rises after 20 clocks → no DTACK; the next RAM cycle acks with RAM_WAIT timing, confirming the counter was cleared.
